imem_loader_ctrl: RTL
=====================

# imem_loader_ctrl

Synthesizable program loader and run controller for the pipelined RISC-V core. It streams a program into instruction memory over a valid/ready port while holding the core in reset, then releases the core and watches fetch for a halt instruction. A cycle-budget watchdog bounds the run, and status is reported on completion. It replaces hand-poked memory writes and fixed-delay termination, and works for any memory depth, data width and timeout.

## Interface
- XLEN, 32, instruction/PC width
- IMEM_DEPTH, 256, instruction memory words (power of two, ≥2)
- ADDR_W, $clog2(IMEM_DEPTH), word address width
- TIMEOUT_CYCLES, 1024, maximum RUN cycles before abort (≥1)
- CNT_W, 32, cycle counter width
- HALT_INSTR, 32'h0000006F, halt encoding (jal x0,0)

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  pulse; begin a load (honoured in IDLE and DONE)
- abort  in  1  return to IDLE from any state
- load_valid  in  1  program word valid
- load_ready  out  1  loader accepts word
- load_data  in  XLEN  program word
- load_last  in  1  final word of program
- imem_we  out  1  instruction memory write enable
- imem_waddr  out  ADDR_W  word address
- imem_wdata  out  XLEN  write data
- cpu_reset  out  1  active-high reset to core
- instr_in  in  XLEN  fetched instruction from core
- pc_in  in  XLEN  fetch PC from core
- busy  out  1  state is LOAD, FILL or RUN
- done  out  1  state is DONE
- timed_out  out  1  run ended by watchdog
- load_ovf  out  1  IMEM_DEPTH words received without load_last
- halt_pc  out  XLEN  pc_in captured at halt
- cycle_count  out  CNT_W  RUN cycles elapsed
- words_loaded  out  ADDR_W+1  words accepted

## Operation
- States: IDLE, LOAD, FILL, RUN, DONE.
- Reset values: state IDLE, cpu_reset=1, load_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, all flags 0, halt_pc=0, cycle_count=0, words_loaded=0.
- IDLE/DONE + start → LOAD. Entry clears the flags, cycle_count, words_loaded and write pointer.
- LOAD: load_ready=1. A word is accepted on load_valid&&load_ready and written at pointer, then the pointer increments.
  - Accept with load_last → FILL if CLEAR enabled and pointer<IMEM_DEPTH-1, otherwise RUN.
  - Accept at pointer IMEM_DEPTH-1 without load_last → load_ovf=1, → DONE. The core never runs.
- FILL: writes NOP (32'h00000013) to every remaining address, one per cycle, through the last address, then → RUN.
- RUN: cpu_reset=0. cycle_count increments each RUN cycle.
  - instr_in==HALT_INSTR → DONE, halt_pc←pc_in.
  - cycle_count reaches TIMEOUT_CYCLES → DONE, timed_out=1.
  - Halt and timeout in the same cycle: halt wins, timed_out=0.
- DONE: cpu_reset=1. Status holds until start or abort.
- abort: → IDLE next edge, cpu_reset=1, load_ready=0. Flags are not cleared. abort outranks start and load handshakes in the same cycle.
- start outside IDLE/DONE is ignored.
- Asynchronous reset mid-LOAD or mid-RUN: immediate return to reset values. Partially written memory is not restored.

## Timing
- imem_we/waddr/wdata are registered: the write appears one cycle after the accepting edge and is a single-cycle pulse per word.
- load_ready drops combinationally-free, registered, in the cycle after the last/overflow accept. No word is accepted after load_last.
- cpu_reset falls on the edge entering RUN and rises on the edge entering DONE or IDLE.
- cycle_count=1 in the first RUN cycle.
- Halt is detected in the cycle it appears on instr_in. The first RUN cycle is included.

## Configuration
- IMEM_LOADER_CLEAR_EN defined: the FILL state exists and unloaded words are NOP-filled before RUN.
- Not defined: LOAD goes directly to RUN. Unwritten words keep prior contents. FILL is unreachable and not compiled.

## Structure
- Shared package riscv_tb_pkg holds:
  - the state enum;
  - NOP_INSTR (32'h00000013);
  - the default HALT_INSTR.
- One sub-module, run_watchdog: cycle counter with clear, enable and terminal-count compare against TIMEOUT_CYCLES.

## Test plan
- Load 4 words (addi x1,x0,5; addi x2,x0,10; add x3,x1,x2; 0x0000006F), last on word 4 → four imem_we pulses at addresses 0–3, then RUN. done=1, halt_pc=0x0000000C, timed_out=0.
- Program with no halt, TIMEOUT_CYCLES=16 → DONE after cycle_count=16, timed_out=1, cpu_reset=1.
- Stream IMEM_DEPTH=8 words without load_last → load_ovf=1, cpu_reset never falls, words_loaded=8.
- load_valid gapped every other cycle with 3 words → writes only on accepted cycles, addresses contiguous 0–2.
- With IMEM_LOADER_CLEAR_EN, depth 8, 3 words → addresses 3–7 written with 32'h00000013 before RUN. Without the macro, RUN starts the cycle after word 3 is accepted.
- abort mid-RUN → IDLE, cpu_reset=1. Reset asserted mid-LOAD → all outputs at reset values asynchronously.

Source files
------------

// File: rtl/riscv_tb_pkg.sv
// Shared types and constants for the instruction-memory loader / run controller.
// Holds the controller state enum, the NOP fill word and the default halt encoding.
package riscv_tb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FILL,
        ST_RUN,
        ST_DONE
    } ldr_state_e;

    localparam logic [31:0] NOP_INSTR          = 32'h0000_0013;  // addi x0,x0,0
    localparam logic [31:0] DEFAULT_HALT_INSTR = 32'h0000_006F;  // jal x0,0

endpackage

// File: rtl/run_watchdog.sv
// Run-cycle counter: synchronous clear, count enable and a terminal-count flag
// that goes high once the count equals TIMEOUT_CYCLES.
module run_watchdog #(
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             expired
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign count   = count_reg;
    assign expired = (count_reg == CNT_W'(TIMEOUT_CYCLES));

endmodule

// File: rtl/imem_loader_ctrl.sv
// Program loader and run controller: streams a program into IMEM, releases the core,
// stops on halt fetch or watchdog. Optional NOP fill of unused words: IMEM_LOADER_CLEAR_EN.
module imem_loader_ctrl
    import riscv_tb_pkg::*;
#(
    parameter int              XLEN           = 32,
    parameter int              IMEM_DEPTH     = 256,
    parameter int              ADDR_W         = $clog2(IMEM_DEPTH),
    parameter int              TIMEOUT_CYCLES = 1024,
    parameter int              CNT_W          = 32,
    parameter logic [XLEN-1:0] HALT_INSTR     = XLEN'(DEFAULT_HALT_INSTR)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [XLEN-1:0]   load_data,
    input  logic              load_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [XLEN-1:0]   imem_wdata,
    output logic              cpu_reset,
    input  logic [XLEN-1:0]   instr_in,
    input  logic [XLEN-1:0]   pc_in,
    output logic              busy,
    output logic              done,
    output logic              timed_out,
    output logic              load_ovf,
    output logic [XLEN-1:0]   halt_pc,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_DEPTH - 1);

    ldr_state_e        state_reg, state_next;
    logic [ADDR_W-1:0] ptr_reg;
    logic [ADDR_W:0]   words_reg;
    logic              ovf_reg, tmo_reg;
    logic [XLEN-1:0]   halt_pc_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] waddr_reg;
    logic [XLEN-1:0]   wdata_reg;
    logic              load_ready_reg, cpu_reset_reg;

    logic start_take, accept, halt_hit, wd_expired;

    // abort outranks every other event, so it masks the start and handshake qualifiers
    assign start_take = start && !abort && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
    assign accept     = (state_reg == ST_LOAD) && load_ready_reg && load_valid && !abort;
    assign halt_hit   = (state_reg == ST_RUN) && (instr_in == HALT_INSTR);

    run_watchdog #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_run_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (start_take),
        .enable  (state_next == ST_RUN),
        .count   (cycle_count),
        .expired (wd_expired)
    );

    always_comb begin
        state_next = state_reg;
        if (abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) state_next = ST_LOAD;
                end
                ST_LOAD: begin
                    if (accept) begin
                        if (load_last) begin
`ifdef IMEM_LOADER_CLEAR_EN
                            state_next = (ptr_reg != LAST_ADDR) ? ST_FILL : ST_RUN;
`else
                            state_next = ST_RUN;
`endif
                        end else if (ptr_reg == LAST_ADDR) begin
                            state_next = ST_DONE;
                        end
                    end
                end
`ifdef IMEM_LOADER_CLEAR_EN
                ST_FILL: begin
                    if (ptr_reg == LAST_ADDR) state_next = ST_RUN;
                end
`endif
                ST_RUN: begin
                    if (halt_hit || wd_expired) state_next = ST_DONE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            ptr_reg        <= '0;
            words_reg      <= '0;
            ovf_reg        <= 1'b0;
            tmo_reg        <= 1'b0;
            halt_pc_reg    <= '0;
            we_reg         <= 1'b0;
            waddr_reg      <= '0;
            wdata_reg      <= '0;
            load_ready_reg <= 1'b0;
            cpu_reset_reg  <= 1'b1;
        end else begin
            state_reg      <= state_next;
            load_ready_reg <= (state_next == ST_LOAD);
            cpu_reset_reg  <= (state_next != ST_RUN);
            we_reg         <= 1'b0;

            if (start_take) begin
                ptr_reg   <= '0;
                words_reg <= '0;
                ovf_reg   <= 1'b0;
                tmo_reg   <= 1'b0;
            end

            if (accept) begin
                we_reg    <= 1'b1;
                waddr_reg <= ptr_reg;
                wdata_reg <= load_data;
                ptr_reg   <= ptr_reg + ADDR_W'(1);
                words_reg <= words_reg + (ADDR_W + 1)'(1);
                if (!load_last && (ptr_reg == LAST_ADDR)) ovf_reg <= 1'b1;
            end

`ifdef IMEM_LOADER_CLEAR_EN
            if ((state_reg == ST_FILL) && !abort) begin
                we_reg    <= 1'b1;
                waddr_reg <= ptr_reg;
                wdata_reg <= XLEN'(NOP_INSTR);
                ptr_reg   <= ptr_reg + ADDR_W'(1);
            end
`endif

            // a halt in the terminal-count cycle still counts as a clean halt
            if ((state_reg == ST_RUN) && !abort) begin
                if (halt_hit) begin
                    halt_pc_reg <= pc_in;
                end else if (wd_expired) begin
                    tmo_reg <= 1'b1;
                end
            end
        end
    end

    assign load_ready   = load_ready_reg;
    assign cpu_reset    = cpu_reset_reg;
    assign imem_we      = we_reg;
    assign imem_waddr   = waddr_reg;
    assign imem_wdata   = wdata_reg;
    assign busy         = (state_reg == ST_LOAD) || (state_reg == ST_FILL) || (state_reg == ST_RUN);
    assign done         = (state_reg == ST_DONE);
    assign timed_out    = tmo_reg;
    assign load_ovf     = ovf_reg;
    assign halt_pc      = halt_pc_reg;
    assign words_loaded = words_reg;

endmodule
